// File: rtl/mhsa_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mhsa_seq
//  Brief    : MHSA job sequencer. Streams IN_WORDS words from usram into the
//             compute core, writes OUT_WORDS results back, and shares the
//             single usram port with host writes (host always wins).
//  Revision : 1.0 - initial release
// ============================================================================
module mhsa_seq #(
    parameter int IN_WORDS  = 64,
    parameter int OUT_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] start,
    input  logic [31:0] input_base,
    input  logic [31:0] output_base,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [63:0] host_wdata,
    output logic        usram_en,
    output logic        usram_we,
    output logic [15:0] usram_addr,
    output logic [63:0] usram_wdata,
    input  logic [63:0] usram_rdata,
    output logic        core_start,
    output logic        core_in_valid,
    output logic [63:0] core_in_data,
    input  logic        core_in_ready,
    input  logic        core_out_valid,
    input  logic [63:0] core_out_data,
    output logic        core_out_ready,
    output logic        busy,
    output logic        done_pulse
);

    localparam int               LEN_W       = 16;
    localparam logic [LEN_W-1:0] c_in_words  = LEN_W'(IN_WORDS);
    localparam logic [LEN_W-1:0] c_out_last  = LEN_W'(OUT_WORDS - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_store = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_start_q;
    logic             r_core_start;
    logic [15:0]      r_in_base;
    logic [15:0]      r_out_base;
    logic [LEN_W-1:0] r_issued;
    logic [LEN_W-1:0] r_returned;
    logic [LEN_W-1:0] r_consumed;
    logic [LEN_W-1:0] r_stored;
    logic             r_inflight;
    logic [63:0]      r_fifo_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_fifo_count;

    logic             w_start_edge;
    logic [1:0]       w_occupancy;
    logic             w_rd_issue;
    logic             w_fifo_empty;
    logic             w_in_pop;
    logic             w_bypass;
    logic             w_push;
    logic             w_fifo_pop;
    logic             w_st_hs;
    logic             w_load_done;

    // Bits of the CSR/address inputs that this block does not decode
    logic             w_unused;
    assign w_unused = &{1'b0, start[31:1], input_base[31:19], input_base[2:0],
                        output_base[31:19], output_base[2:0], host_addr[31:16]};

    assign w_start_edge = start[0] & ~r_start_q;
    assign w_occupancy  = r_fifo_count + {1'b0, r_inflight};
    assign w_rd_issue   = (r_state == c_st_load) & ~host_we &
                          (r_issued < c_in_words) & (w_occupancy < 2'd2);
    assign w_fifo_empty = (r_fifo_count == 2'd0);

    // Returning read data is offered straight to the core when the FIFO is
    // empty, so the first word is visible in the cycle it comes back.
    assign w_in_pop     = core_in_valid & core_in_ready;
    assign w_bypass     = w_in_pop & w_fifo_empty;
    assign w_push       = r_inflight & ~w_bypass;
    assign w_fifo_pop   = w_in_pop & ~w_fifo_empty;
    assign w_st_hs      = core_out_ready & core_out_valid;
    assign w_load_done  = (r_issued == c_in_words) & (r_returned == c_in_words) &
                          (r_consumed == c_in_words) & w_fifo_empty & ~r_inflight;

    assign core_start   = r_core_start;
    assign core_in_data = !w_fifo_empty ? r_fifo_mem[r_rd_ptr] :
                          (r_inflight ? usram_rdata : 64'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_start_edge) w_state_nxt = c_st_load;
            c_st_load:  if (w_load_done) w_state_nxt = c_st_store;
            c_st_store: if (w_st_hs && (r_stored == c_out_last)) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // State-decoded outputs and usram port arbitration (host first)
    always_comb begin
        busy           = (r_state != c_st_idle);
        done_pulse     = (r_state == c_st_done);
        core_in_valid  = (r_state == c_st_load) & (~w_fifo_empty | r_inflight);
        core_out_ready = (r_state == c_st_store) & ~host_we;
        usram_en       = 1'b0;
        usram_we       = 1'b0;
        usram_addr     = 16'd0;
        usram_wdata    = 64'd0;
        if (host_we) begin
            usram_en    = 1'b1;
            usram_we    = 1'b1;
            usram_addr  = host_addr[15:0];
            usram_wdata = host_wdata;
        end else if (w_rd_issue) begin
            usram_en    = 1'b1;
            usram_addr  = r_in_base + r_issued;
        end else if (w_st_hs) begin
            usram_en    = 1'b1;
            usram_we    = 1'b1;
            usram_addr  = r_out_base + r_stored;
            usram_wdata = core_out_data;
        end
    end

    // Job bookkeeping: start edge detect, bases, counters, read FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q     <= 1'b0;
            r_core_start  <= 1'b0;
            r_in_base     <= 16'd0;
            r_out_base    <= 16'd0;
            r_issued      <= '0;
            r_returned    <= '0;
            r_consumed    <= '0;
            r_stored      <= '0;
            r_inflight    <= 1'b0;
            r_fifo_mem[0] <= 64'd0;
            r_fifo_mem[1] <= 64'd0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_fifo_count  <= 2'd0;
        end else begin
            r_start_q    <= start[0];
            r_core_start <= (r_state == c_st_idle) & w_start_edge;
            r_inflight   <= w_rd_issue;
            if ((r_state == c_st_idle) && w_start_edge) begin
                r_in_base    <= input_base[18:3];
                r_out_base   <= output_base[18:3];
                r_issued     <= '0;
                r_returned   <= '0;
                r_consumed   <= '0;
                r_stored     <= '0;
                r_wr_ptr     <= 1'b0;
                r_rd_ptr     <= 1'b0;
                r_fifo_count <= 2'd0;
            end else begin
                if (w_rd_issue) r_issued <= r_issued + 1'b1;
                if (r_inflight) r_returned <= r_returned + 1'b1;
                if (w_in_pop) r_consumed <= r_consumed + 1'b1;
                if (w_st_hs) r_stored <= r_stored + 1'b1;
                if (w_push) begin
                    r_fifo_mem[r_wr_ptr] <= usram_rdata;
                    r_wr_ptr             <= ~r_wr_ptr;
                end
                if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
                r_fifo_count <= r_fifo_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mhsa_seq.md
# mhsa_seq

Sequencer and usram port owner for the MHSA accelerator. On a rising edge of CSR `start[0]` it streams `IN_WORDS` 64-bit words from usram (starting at `input_base`) into the compute core, then writes `OUT_WORDS` result words back to usram (starting at `output_base`) and pulses `done_pulse`. It also arbitrates the single usram port between host 64-bit writes (merged by the ICB interface unit) and its own reads/writes. Host writes always win.

## Interface
- `IN_WORDS`, 64, words loaded per job (1..65535)
- `OUT_WORDS`, 64, words stored per job (1..65535)
- `clk` input 1: clock; all state on rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `start` input 32: start CSR; bit 0 is used
- `input_base` input 32: byte address of input block
- `output_base` input 32: byte address of output block
- `host_we` input 1: host 64-bit write request, single-cycle
- `host_addr` input 32: host word address, bits [15:0] used
- `host_wdata` input 64: host write data
- `usram_en` output 1: usram port access
- `usram_we` output 1: usram write (`usram_en` also high)
- `usram_addr` output 16: usram word address
- `usram_wdata` output 64: usram write data
- `usram_rdata` input 64: read data, valid 1 cycle after a read access
- `core_start` output 1: one-cycle pulse, job begins
- `core_in_valid` / `core_in_data` output 1/64: input stream to core
- `core_in_ready` input 1: core accepts input word
- `core_out_valid` / `core_out_data` input 1/64: result stream from core
- `core_out_ready` output 1: sequencer accepts result word
- `busy` output 1: high in any state other than IDLE
- `done_pulse` output 1: one-cycle pulse at job end

## Operation
- Word addresses: `in_base_w = input_base[18:3]` and `out_base_w = output_base[18:3]`, both captured at job start. The address for word k is `base_w + k` mod 2^16, so wrap past 0xFFFF goes to 0x0000.
- `start_edge = start[0] & ~start_q`, with `start_q` registered every cycle. An edge while `busy` is ignored.
- FSM:
  - IDLE: on `start_edge`, go to LOAD, pulse `core_start`, capture bases, clear counters.
  - LOAD: read `IN_WORDS` words into a 2-entry FIFO and present the FIFO head on `core_in_*`. When all words have been issued, all have returned, and the FIFO is empty, go to STORE.
  - STORE: `core_out_ready = ~host_we`. Each handshake writes `core_out_data` to `out_base_w + k`. After `OUT_WORDS` handshakes, go to DONE.
  - DONE: `done_pulse = 1` for one cycle, then go to IDLE.
- Read issue rule in LOAD: issue when `~host_we`, issued < `IN_WORDS`, and `fifo_count + inflight < 2` (inflight is 0 or 1). The FIFO never overflows.
- Port mux, combinational:
  - If `host_we`: `usram_en=1`, `usram_we=1`, and host address/data are passed through.
  - Else if a sequencer read is issued: `usram_en=1`, `usram_we=0`.
  - Else if a STORE handshake occurs: `usram_en=1`, `usram_we=1`, with `core_out_data`.
  - Otherwise `usram_en=0`.
- `core_out_ready` is 0 outside STORE. `core_in_valid` is 0 outside LOAD.
- Counters are `LEN_W = 16` bits: issued, returned, consumed, stored.

## Timing
- Reset values of all outputs are 0: `usram_en`, `usram_we`, `usram_addr`, `usram_wdata`, `core_start`, `core_in_valid`, `core_in_data`, `core_out_ready`, `busy`, `done_pulse`. FSM resets to IDLE; FIFO and counters reset to 0.
- Reset mid-job aborts immediately. No done pulse is produced; the next job starts only on a fresh `start` edge after reset.
- `start_edge` seen at cycle T gives `core_start=1`, `busy=1`, and the first read at T+1. Data lands in the FIFO at T+2, and `core_in_valid=1` at T+2.
- With no host traffic and `core_in_ready=1`, LOAD sustains 1 word/cycle.
- FIFO simultaneous push and pop is allowed; the count is unchanged.
- A `host_we` in the same cycle as a read or STORE handshake defers the sequencer access by exactly one cycle. No read or write is lost or duplicated.
- STORE handshake at cycle t gives a usram write in the same cycle t. The final handshake at t leads to DONE at t+1 (`done_pulse`), then IDLE with `busy=0` at t+2.
- `done_pulse` and `core_start` are each high for exactly one cycle per job.

## Test plan
- Basic job: `IN_WORDS=4`, `OUT_WORDS=4`, `input_base=0x100`, `output_base=0x200`, core always ready.
  - Reads hit word addresses 0x20..0x23, and `core_in_data` matches preloaded usram values.
  - Writes hit 0x40..0x43.
  - `done_pulse` occurs once; `busy` falls 2 cycles after the last store.
- Backpressure: `core_in_ready` toggles 1,0,0,1 repeatedly.
  - No word is dropped or duplicated.
  - `usram_en` reads never exceed 2 outstanding.
- Host priority: assert `host_we` (addr 0x30, data 0xA5A5…) every other cycle during LOAD and STORE.
  - Host writes are landed exactly.
  - All `IN_WORDS`/`OUT_WORDS` complete in order, with latency extended by the number of collisions.
- Wrap-around: `input_base = 0x7FFF0` (word 0xFFFE), `IN_WORDS=4`.
  - Reads hit addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Start while busy: a second `start` rising edge mid-LOAD is ignored, and exactly one `done_pulse` occurs. Holding `start[0]` high after the job does not retrigger.
- Reset mid-STORE: drop `rst_n` asynchronously.
  - All outputs go to 0 without waiting for a clock.
  - No `done_pulse`; FSM is in IDLE.
  - A new start edge then runs a full job correctly.
